// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns decoded instruction requests into 32-bit words
// and writes them sequentially into instruction memory, finishing with a terminator.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_func3,
  input  logic              in_func7_5,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              done
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] K_LW   = 4'd0;
  localparam logic [3:0] K_SW   = 4'd1;
  localparam logic [3:0] K_R    = 4'd2;
  localparam logic [3:0] K_B    = 4'd3;
  localparam logic [3:0] K_I    = 4'd4;
  localparam logic [3:0] K_JAL  = 4'd5;
  localparam logic [3:0] K_JALR = 4'd6;
  localparam logic [3:0] K_LUI  = 4'd7;
  localparam logic [3:0] K_END  = 4'd8;

  localparam logic [1:0] E_NONE = 2'd0;
  localparam logic [1:0] E_IMM  = 2'd1;
  localparam logic [1:0] E_FULL = 2'd2;
  localparam logic [1:0] E_KIND = 2'd3;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

  typedef struct packed {
    logic [3:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f75;
    logic [31:0] imm;
  } req_t;

  logic [1:0]        state_q, state_d;
  req_t              req_q, req_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              done_q, done_d;

  logic [31:0]        word_c;
  logic               imm_ok_c;
  logic [1:0]         code_c;
  logic signed [31:0] imm_s;
  logic               fits12_c;

  assign imm_s    = $signed(req_q.imm);
  assign fits12_c = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);

  // Field packing and immediate range check for the captured request
  always_comb begin
    word_c   = '0;
    imm_ok_c = 1'b1;
    case (req_q.kind)
      K_LW: begin
        word_c   = {req_q.imm[11:0], req_q.rs1, 3'b010, req_q.rd, 7'b0000011};
        imm_ok_c = fits12_c;
      end
      K_SW: begin
        word_c   = {req_q.imm[11:5], req_q.rs2, req_q.rs1, 3'b010, req_q.imm[4:0], 7'b0100011};
        imm_ok_c = fits12_c;
      end
      K_R: word_c = {1'b0, req_q.f75, 5'b00000, req_q.rs2, req_q.rs1, req_q.f3, req_q.rd, 7'b0110011};
      K_B: begin
        word_c   = {req_q.imm[12], req_q.imm[10:5], req_q.rs2, req_q.rs1, req_q.f3,
                    req_q.imm[4:1], req_q.imm[11], 7'b1100011};
        imm_ok_c = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !req_q.imm[0];
      end
      K_I: begin
        word_c   = {req_q.imm[11:0], req_q.rs1, req_q.f3, req_q.rd, 7'b0010011};
        imm_ok_c = fits12_c;
      end
      K_JAL: begin
        word_c   = {req_q.imm[20], req_q.imm[10:1], req_q.imm[11], req_q.imm[19:12], req_q.rd, 7'b1101111};
        imm_ok_c = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !req_q.imm[0];
      end
      K_JALR: begin
        word_c   = {req_q.imm[11:0], req_q.rs1, 3'b000, req_q.rd, 7'b1100111};
        imm_ok_c = fits12_c;
      end
      K_LUI: begin
        word_c   = {req_q.imm[31:12], req_q.rd, 7'b0110111};
        imm_ok_c = (req_q.imm[11:0] == 12'd0);
      end
      K_END:   word_c = 32'hFFFF_FFFF;
      default: word_c = '0;
    endcase
  end

  // Rejection priority: illegal kind, then full, then immediate range
  always_comb begin
    code_c = E_NONE;
    if (req_q.kind > K_END)                           code_c = E_KIND;
    else if (req_q.kind == K_END && count_q == CNT_FULL) code_c = E_FULL;
    else if (req_q.kind != K_END && count_q == CNT_LAST) code_c = E_FULL;
    else if (!imm_ok_c)                               code_c = E_IMM;
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    err_d       = 1'b0;
    err_code_d  = E_NONE;
    done_d      = done_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          req_d   = '{kind: in_kind, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                      f3: in_func3, f75: in_func7_5, imm: in_imm};
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (code_c != E_NONE) begin
          err_d      = 1'b1;
          err_code_d = code_c;
          if (req_q.kind == K_END && code_c == E_FULL) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          mem_wdata_d = word_c;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          count_d    = count_q + CNT_W'(1);
          if (req_q.kind == K_END) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_DONE;
    endcase
    in_ready_d = (state_d == S_IDLE);
    mem_we_d   = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= ADDR_BASE;
      mem_wdata_q <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      err_code_q  <= E_NONE;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q     <= count_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign done      = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: random and directed requests, expected
// words/errors from an arithmetic reference model, checked by a separate monitor.
module tb_instr_encoder;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned BASE_ADDR = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_kind = '0;
  logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]        in_func3 = '0;
  logic              in_func7_5 = 1'b0;
  logic [31:0]       in_imm = '0;
  logic              mem_we;
  logic              mem_ack = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              err;
  logic [1:0]        err_code;
  logic              done;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_count  = 0;
  bit   mon_off  = 1'b1;
  bit   hold_ack = 1'b0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_func3(in_func3), .in_func7_5(in_func7_5), .in_imm(in_imm),
    .mem_we(mem_we), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .err(err), .err_code(err_code), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Reference model: instruction word from field arithmetic, error code from the rejection rules
  function automatic exp_t model(input int k, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic f75,
                                 input logic [31:0] imm);
    exp_t e;
    int s;
    bit ok;
    logic [31:0] rdv, r1v, r2v, f3v, i12;
    s   = int'($signed(imm));
    rdv = 32'(rd) << 7;
    r1v = 32'(rs1) << 15;
    r2v = 32'(rs2) << 20;
    f3v = 32'(f3) << 12;
    i12 = imm & 32'hFFF;
    ok  = 1'b1;
    e.word = '0;
    e.addr = 32'(BASE_ADDR) + 32'(m_count);
    case (k)
      0: begin e.word = (i12 << 20) | r1v | (32'd2 << 12) | rdv | 32'h03; ok = (s >= -2048 && s <= 2047); end
      1: begin
        e.word = (((imm >> 5) & 32'h7F) << 25) | r2v | r1v | (32'd2 << 12) | ((imm & 32'h1F) << 7) | 32'h23;
        ok = (s >= -2048 && s <= 2047);
      end
      2: e.word = (32'(f75) << 30) | r2v | r1v | f3v | rdv | 32'h33;
      3: begin
        e.word = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | r2v | r1v | f3v |
                 (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
        ok = (s >= -4096 && s <= 4094 && (s % 2) == 0);
      end
      4: begin e.word = (i12 << 20) | r1v | f3v | rdv | 32'h13; ok = (s >= -2048 && s <= 2047); end
      5: begin
        e.word = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                 (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | rdv | 32'h6F;
        ok = (s >= -1048576 && s <= 1048574 && (s % 2) == 0);
      end
      6: begin e.word = (i12 << 20) | r1v | rdv | 32'h67; ok = (s >= -2048 && s <= 2047); end
      7: begin e.word = (imm & 32'hFFFFF000) | rdv | 32'h37; ok = (i12 == 0); end
      8: e.word = 32'hFFFFFFFF;
      default: e.word = '0;
    endcase
    if (k > 8)                                          e.code = 2'd3;
    else if (k != 8 && m_count == int'(DEPTH) - 1)      e.code = 2'd2;
    else if (k == 8 && m_count == int'(DEPTH))          e.code = 2'd2;
    else if (!ok)                                       e.code = 2'd1;
    else                                                e.code = 2'd0;
    e.is_err = (e.code != 2'd0);
    return e;
  endfunction

  task automatic send(input int k, input int rd, input int rs1, input int rs2, input int f3,
                      input int f75, input logic [31:0] imm, input bit ovr, input logic [31:0] ovr_word);
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: in_ready got 0, expected 1");
    end else begin
      e = model(k, 5'(rd), 5'(rs1), 5'(rs2), 3'(f3), 1'(f75), imm);
      if (ovr && !e.is_err) e.word = ovr_word;
      exp_q.push_back(e);
      if (!e.is_err) m_count++;
      in_valid = 1'b1; in_kind = 4'(k); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
      in_func3 = 3'(f3); in_func7_5 = 1'(f75); in_imm = imm;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_kind = 4'($urandom); in_rd = 5'($urandom); in_imm = $urandom;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && (in_ready || done)) break;
    end
    chk("pending_responses", 32'(exp_q.size()), 32'd0);
    chk("count", 32'(count), 32'(m_count));
  endtask

  task automatic wait_we();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_we) break;
    end
    chk("mem_we_rise", 32'(mem_we), 32'd1);
  endtask

  task automatic send_random();
    int k, w, sel;
    logic [31:0] imm;
    sel = int'($urandom_range(0, 19));
    k   = (sel < 16) ? sel % 8 : int'($urandom_range(9, 15));
    w   = (k == 5) ? 21 : (k == 3) ? 13 : 12;
    imm = 32'($urandom_range(0, (32'd1 << w) - 1)) - (32'd1 << (w - 1));
    if (k == 3 || k == 5) imm = imm & ~32'd1;
    sel = int'($urandom_range(0, 9));
    if (sel == 0) imm = $urandom;
    if (sel == 1) imm = (32'd1 << (w - 1)) - 32'd1;
    if (sel == 2) imm = 32'd0 - (32'd1 << (w - 1));
    if (sel == 3) imm = imm | 32'd1;
    if (k == 7) imm = (sel == 3) ? ($urandom | 32'h800) : ($urandom & 32'hFFFFF000);
    send(k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
         int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), imm, 1'b0, 32'd0);
  endtask

  // Memory acknowledge: random back-pressure unless held off
  always @(posedge clk) begin
    #1;
    mem_ack = hold_ack ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: every cycle the DUT presents a write or an error, compare against the queue head
  always @(negedge clk) begin
    if (rst && !mon_off && (err || mem_we)) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_output: err=%0b mem_we=%0b addr=%0d, expected no activity", err, mem_we, mem_addr);
      end else begin
        mon_e = exp_q[0];
        chk("err_flag", 32'(err), 32'(mon_e.is_err));
        chk("mem_addr", 32'(mem_addr), mon_e.addr);
        if (err) begin
          chk("err_code", 32'(err_code), 32'(mon_e.code));
          chk("we_during_err", 32'(mem_we), 32'd0);
          void'(exp_q.pop_front());
        end else begin
          chk("mem_wdata", mem_wdata, mon_e.word);
          if (mem_ack) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'(BASE_ADDR));
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mon_off = 1'b0;

    // Known-answer words
    send(4, 1, 0, 0, 0, 0, 32'd5, 1'b1, 32'h00500093);
    send(0, 2, 1, 0, 0, 0, 32'd8, 1'b1, 32'h0080A103);
    send(1, 0, 1, 2, 0, 0, 32'd4, 1'b1, 32'h0020A223);
    send(2, 3, 1, 2, 0, 1, 32'd0, 1'b1, 32'h402081B3);
    send(3, 0, 1, 2, 0, 0, -32'sd4, 1'b1, 32'hFE208EE3);
    send(5, 1, 0, 0, 0, 0, 32'd8, 1'b1, 32'h008000EF);
    send(7, 5, 0, 0, 0, 0, 32'h12345000, 1'b1, 32'h123452B7);
    drain();

    // Rejections and immediate boundaries
    send(4, 1, 0, 0, 0, 0, 32'd2048, 1'b0, 32'd0);
    send(3, 0, 1, 2, 0, 0, 32'd3, 1'b0, 32'd0);
    send(12, 1, 1, 1, 0, 0, 32'd0, 1'b0, 32'd0);
    send(7, 5, 0, 0, 0, 0, 32'h12345001, 1'b0, 32'd0);
    send(5, 1, 0, 0, 0, 0, -32'sd1048576, 1'b0, 32'd0);
    send(3, 0, 3, 4, 1, 0, 32'd4094, 1'b0, 32'd0);
    send(6, 7, 8, 0, 0, 0, -32'sd2049, 1'b0, 32'd0);
    drain();

    // Memory stall: write held until ack
    hold_ack = 1'b1;
    send(4, 9, 2, 0, 6, 0, 32'd2047, 1'b0, 32'd0);
    wait_we();
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_mem_we", 32'(mem_we), 32'd1);
    end
    hold_ack = 1'b0;
    drain();

    // Random traffic up to the last free slot
    for (int it = 0; it < 400 && m_count < int'(DEPTH) - 1; it++) send_random();
    drain();

    // Full: only the terminator may use the last slot
    send(4, 1, 1, 0, 0, 0, 32'd1, 1'b0, 32'd0);
    send(13, 1, 1, 0, 0, 0, 32'd1, 1'b0, 32'd0);
    send(4, 1, 1, 0, 0, 0, 32'd5000, 1'b0, 32'd0);
    send(8, 0, 0, 0, 0, 0, 32'd0, 1'b1, 32'hFFFFFFFF);
    drain();
    chk("done_set", 32'(done), 32'd1);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("done_addr", 32'(mem_addr), 32'(BASE_ADDR + DEPTH));
    in_valid = 1'b1; in_kind = 4'd4; in_imm = 32'd1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    chk("done_hold", 32'(done), 32'd1);
    chk("done_count", 32'(count), 32'(DEPTH));

    // Reset out of DONE, then reset in the middle of a stalled write
    rst = 1'b0;
    exp_q.delete();
    m_count = 0;
    @(negedge clk);
    rst = 1'b1;
    chk("rerst_done", 32'(done), 32'd0);
    hold_ack = 1'b1;
    send(4, 1, 0, 0, 0, 0, 32'd5, 1'b1, 32'h00500093);
    wait_we();
    @(posedge clk);
    #3;
    mon_off = 1'b1;
    rst = 1'b0;
    #1;
    chk("async_in_ready", 32'(in_ready), 32'd1);
    chk("async_mem_we", 32'(mem_we), 32'd0);
    chk("async_mem_addr", 32'(mem_addr), 32'(BASE_ADDR));
    chk("async_mem_wdata", mem_wdata, 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    exp_q.delete();
    m_count = 0;
    hold_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mon_off = 1'b0;
    send(2, 3, 1, 2, 0, 1, 32'd0, 1'b1, 32'h402081B3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
